// File: rtl/time_skew_split.sv
// time_skew_split: splits an aligned {MSB, LSB} word into two fields and
// emits the LSB field SKEW cycles after the MSB field. This reproduces the
// stage-1/stage-2 timing seen at the inputs of the two-stage time aligner.
module time_skew_split #(
    parameter int MSB_W = 3,
    parameter int LSB_W = 3,
    parameter int SKEW  = 1,
    parameter int CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [MSB_W+LSB_W-1:0] din_i,
    input  logic                   din_valid_i,
    output logic [MSB_W-1:0]       msb_o,
    output logic                   msb_valid_o,
    output logic [LSB_W-1:0]       lsb_o,
    output logic                   lsb_valid_o,
    output logic                   busy_o,
    output logic [CNT_W-1:0]       words_o
);

    // One extra bit over what SKEW needs keeps the count clear of overflow.
    localparam int PEND_W = $clog2(SKEW + 1) + 1;

    // A skew outside 1..8 cannot produce the intended timing; stop elaboration.
    generate
        if (SKEW < 1 || SKEW > 8) begin : g_skew_check
            $fatal(1, "time_skew_split: SKEW must be in 1..8");
        end
    endgenerate

    // LSB delay line: data and valid travel together, one stage per cycle.
    logic [LSB_W-1:0] lsb_pipe_reg [SKEW];
    logic             vld_pipe_reg [SKEW];

    logic [MSB_W-1:0]  msb_reg;
    logic              msb_valid_reg;
    logic [LSB_W-1:0]  lsb_reg;
    logic              lsb_valid_reg;
    logic [PEND_W-1:0] pending_reg;
    logic [PEND_W-1:0] pending_next;
    logic              busy_reg;
    logic [CNT_W-1:0]  words_reg;

    logic              exit_valid;
    logic [LSB_W-1:0]  exit_data;

    // The word leaving the last stage is emitted on the following edge.
    assign exit_valid = vld_pipe_reg[SKEW-1];
    assign exit_data  = lsb_pipe_reg[SKEW-1];

    genvar gi;
    generate
        for (gi = 0; gi < SKEW; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                // First stage captures the LSB field of every accepted word.
                always_ff @(posedge clk_i) begin
                    if (reset_i) begin
                        lsb_pipe_reg[gi] <= '0;
                        vld_pipe_reg[gi] <= 1'b0;
                    end else begin
                        lsb_pipe_reg[gi] <= din_i[LSB_W-1:0];
                        vld_pipe_reg[gi] <= din_valid_i;
                    end
                end
            end else begin : g_body
                // Later stages shift unconditionally so gaps are preserved.
                always_ff @(posedge clk_i) begin
                    if (reset_i) begin
                        lsb_pipe_reg[gi] <= '0;
                        vld_pipe_reg[gi] <= 1'b0;
                    end else begin
                        lsb_pipe_reg[gi] <= lsb_pipe_reg[gi-1];
                        vld_pipe_reg[gi] <= vld_pipe_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    // Pending count: up on accept, down on emission, unchanged when both.
    always_comb begin
        pending_next = pending_reg;
        case ({din_valid_i, exit_valid})
            2'b10:   pending_next = pending_reg + PEND_W'(1);
            2'b01:   pending_next = pending_reg - PEND_W'(1);
            default: pending_next = pending_reg;
        endcase
    end

    // MSB path: one-cycle latency, field held between valid words.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            msb_reg       <= '0;
            msb_valid_reg <= 1'b0;
        end else begin
            msb_valid_reg <= din_valid_i;
            if (din_valid_i) begin
                msb_reg <= din_i[MSB_W+LSB_W-1:LSB_W];
            end
        end
    end

    // LSB output stage and emitted-word counter (wraps silently).
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lsb_reg       <= '0;
            lsb_valid_reg <= 1'b0;
            words_reg     <= '0;
        end else begin
            lsb_valid_reg <= exit_valid;
            if (exit_valid) begin
                lsb_reg   <= exit_data;
                words_reg <= words_reg + CNT_W'(1);
            end
        end
    end

    // Pending counter and busy flag share the same register timing.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pending_reg <= '0;
            busy_reg    <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            busy_reg    <= (pending_next != '0);
        end
    end

    assign msb_o       = msb_reg;
    assign msb_valid_o = msb_valid_reg;
    assign lsb_o       = lsb_reg;
    assign lsb_valid_o = lsb_valid_reg;
    assign busy_o      = busy_reg;
    assign words_o     = words_reg;

endmodule
